// File: rtl/sync_filter_edge_if.sv
// Channel bundle for sync_filter_edge: raw inputs plus synchronised, filtered and edge outputs.
// The event flag signals exist only when SYNC_EDGE_FLAG_EN is defined.
interface sync_filter_edge_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] sig_in;
    logic [WIDTH-1:0] sig_sync;
    logic [WIDTH-1:0] sig_filt;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
`ifdef SYNC_EDGE_FLAG_EN
    logic [WIDTH-1:0] evt_clr;
    logic [WIDTH-1:0] rise_flag;
    logic [WIDTH-1:0] fall_flag;

    modport master (
        output sig_in, evt_clr,
        input  sig_sync, sig_filt, rise, fall, rise_flag, fall_flag
    );
    modport slave (
        input  sig_in, evt_clr,
        output sig_sync, sig_filt, rise, fall, rise_flag, fall_flag
    );
`else
    modport master (
        output sig_in,
        input  sig_sync, sig_filt, rise, fall
    );
    modport slave (
        input  sig_in,
        output sig_sync, sig_filt, rise, fall
    );
`endif
endinterface

// File: rtl/sync_filter_edge.sv
// Multi-channel pad synchroniser: flop chain, stability-counter glitch filter, registered edge pulses.
// Define SYNC_EDGE_FLAG_EN to add sticky rise/fall event flags cleared by evt_clr.
module sync_filter_edge #(
    parameter int               WIDTH    = 2,
    parameter int               STAGES   = 2,
    parameter int               FILT_CYC = 3,
    parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b1}}
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_filter_edge_if.slave  bus
);
    localparam int SE    = (STAGES < 2) ? 2 : STAGES;
    localparam int CNT_W = (FILT_CYC < 1) ? 1 : $clog2(FILT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYC);

    logic [WIDTH-1:0] sync_vec;
    logic [WIDTH-1:0] filt_vec;
    logic [WIDTH-1:0] rise_vec;
    logic [WIDTH-1:0] fall_vec;
`ifdef SYNC_EDGE_FLAG_EN
    logic [WIDTH-1:0] rise_flag_vec;
    logic [WIDTH-1:0] fall_flag_vec;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ch
            logic [SE-1:0]    chain_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             filt_reg;
            logic             rise_reg;
            logic             fall_reg;
            logic             sync_bit;
            logic             accept;

            assign sync_bit = chain_reg[SE-1];
            // A differing level is taken only once it has survived FILT_CYC+1 samples.
            assign accept   = (sync_bit != filt_reg) && (cnt_reg == CNT_MAX);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain_reg <= {SE{RST_VAL[gi]}};
                    cnt_reg   <= '0;
                    filt_reg  <= RST_VAL[gi];
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    chain_reg <= {chain_reg[SE-2:0], bus.sig_in[gi]};
                    rise_reg  <= accept & sync_bit;
                    fall_reg  <= accept & ~sync_bit;
                    if (sync_bit == filt_reg || accept) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                    if (accept) begin
                        filt_reg <= sync_bit;
                    end
                end
            end

            assign sync_vec[gi] = sync_bit;
            assign filt_vec[gi] = filt_reg;
            assign rise_vec[gi] = rise_reg;
            assign fall_vec[gi] = fall_reg;

`ifdef SYNC_EDGE_FLAG_EN
            logic rise_flag_reg;
            logic fall_flag_reg;

            // A pulse arriving in the same cycle as a clear keeps the flag set.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rise_flag_reg <= 1'b0;
                    fall_flag_reg <= 1'b0;
                end else begin
                    rise_flag_reg <= rise_reg | (rise_flag_reg & ~bus.evt_clr[gi]);
                    fall_flag_reg <= fall_reg | (fall_flag_reg & ~bus.evt_clr[gi]);
                end
            end

            assign rise_flag_vec[gi] = rise_flag_reg;
            assign fall_flag_vec[gi] = fall_flag_reg;
`endif
        end
    endgenerate

    assign bus.sig_sync = sync_vec;
    assign bus.sig_filt = filt_vec;
    assign bus.rise     = rise_vec;
    assign bus.fall     = fall_vec;
`ifdef SYNC_EDGE_FLAG_EN
    assign bus.rise_flag = rise_flag_vec;
    assign bus.fall_flag = fall_flag_vec;
`endif
endmodule

// File: tb/tb_sync_filter_edge.sv
// Bench for sync_filter_edge: two parameter sets driven together, checked against a sliding-window model.
module tb_sync_filter_edge;
    localparam int         W  = 2;
    localparam logic [1:0] RV = 2'b11;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] stim  = 2'b00;
    logic [1:0] clr   = 2'b00;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    sync_filter_edge_if #(.WIDTH(W)) bus_a ();
    sync_filter_edge_if #(.WIDTH(W)) bus_b ();

    assign bus_a.sig_in = stim;
    assign bus_b.sig_in = stim;
`ifdef SYNC_EDGE_FLAG_EN
    assign bus_a.evt_clr = clr;
    assign bus_b.evt_clr = clr;
`endif

    sync_filter_edge #(.WIDTH(W), .STAGES(2), .FILT_CYC(3), .RST_VAL(RV)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    sync_filter_edge #(.WIDTH(W), .STAGES(3), .FILT_CYC(0), .RST_VAL(RV)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    // Reference model: sync is the input delayed by STAGES edges; the filtered
    // level flips when the last FILT_CYC+1 sampled sync values all disagree with it.
    int         stg [2] = '{2, 3};
    int         fc  [2] = '{3, 0};
    logic [1:0] in_ring  [2][64];
    logic [1:0] syn_ring [2][64];
    int         ni [2];
    int         ns [2];
    logic [1:0] m_sync [2];
    logic [1:0] m_filt [2];
    logic [1:0] m_rise [2];
    logic [1:0] m_fall [2];
    logic [1:0] m_rfl  [2];
    logic [1:0] m_ffl  [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ni[k] = 0; ns[k] = 0;
            m_sync[k] = RV; m_filt[k] = RV;
            m_rise[k] = 2'b00; m_fall[k] = 2'b00;
            m_rfl[k] = 2'b00; m_ffl[k] = 2'b00;
        end
    endtask

    task automatic model_step();
        logic [1:0] samp;
        logic [1:0] acc;
        for (int k = 0; k < 2; k++) begin
            samp = m_sync[k];
            m_rfl[k] = m_rise[k] | (m_rfl[k] & ~clr);
            m_ffl[k] = m_fall[k] | (m_ffl[k] & ~clr);
            syn_ring[k][ns[k] % 64] = samp;
            ns[k]++;
            acc = 2'b00;
            for (int c = 0; c < 2; c++) begin
                if (ns[k] >= fc[k] + 1) begin
                    acc[c] = 1'b1;
                    for (int j = 1; j <= fc[k] + 1; j++)
                        if (syn_ring[k][(ns[k] - j) % 64][c] == m_filt[k][c]) acc[c] = 1'b0;
                end
            end
            m_rise[k] = acc & samp;
            m_fall[k] = acc & ~samp;
            m_filt[k] = (m_filt[k] & ~acc) | (samp & acc);
            in_ring[k][ni[k] % 64] = stim;
            ni[k]++;
            m_sync[k] = (ni[k] >= stg[k]) ? in_ring[k][(ni[k] - stg[k]) % 64] : RV;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a_sync", 32'(bus_a.sig_sync), 32'(m_sync[0]));
        check("a_filt", 32'(bus_a.sig_filt), 32'(m_filt[0]));
        check("a_rise", 32'(bus_a.rise),     32'(m_rise[0]));
        check("a_fall", 32'(bus_a.fall),     32'(m_fall[0]));
        check("b_sync", 32'(bus_b.sig_sync), 32'(m_sync[1]));
        check("b_filt", 32'(bus_b.sig_filt), 32'(m_filt[1]));
        check("b_rise", 32'(bus_b.rise),     32'(m_rise[1]));
        check("b_fall", 32'(bus_b.fall),     32'(m_fall[1]));
`ifdef SYNC_EDGE_FLAG_EN
        check("a_rflag", 32'(bus_a.rise_flag), 32'(m_rfl[0]));
        check("a_fflag", 32'(bus_a.fall_flag), 32'(m_ffl[0]));
        check("b_rflag", 32'(bus_b.rise_flag), 32'(m_rfl[1]));
        check("b_fflag", 32'(bus_b.fall_flag), 32'(m_ffl[1]));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all();
    endtask

    task automatic settle(input logic [1:0] v);
        stim = v;
        for (int i = 0; i < 12; i++) cycle();
    endtask

    initial begin
        int edge_at;
        int n_rise;
        int n_fall;

        // Reset held with inputs opposite to the idle level.
        model_reset();
        for (int i = 0; i < 3; i++) cycle();
        check("rst_sync", 32'(bus_a.sig_sync), 32'(2'b11));
        check("rst_edges", 32'({bus_a.rise, bus_a.fall}), 32'(4'b0000));
        rst_n = 1'b1;
        edge_at = 0;
        for (int i = 1; i <= 9; i++) begin
            cycle();
            if (bus_a.fall == 2'b11 && edge_at == 0) edge_at = i;
        end
        check("rel_fall_edge", 32'(edge_at), 32'(6));
        check("rel_filt", 32'(bus_a.sig_filt), 32'(2'b00));
        $display("reset release: fall seen on edge %0d", edge_at);

        // Clean falling edge on channel 0.
        settle(2'b11);
        stim = 2'b10;
        for (int i = 0; i <= 7; i++) begin
            cycle();
            if (i == 1) check("clean_sync0", 32'(bus_a.sig_sync[0]), 32'(0));
            if (i == 5) check("clean_fall5", 32'({bus_a.fall, bus_a.sig_filt}), 32'(4'b0110));
            if (i == 6) check("clean_fall6", 32'(bus_a.fall), 32'(2'b00));
        end
        $display("clean edge: filt=%b", bus_a.sig_filt);

        // Glitch of 3 cycles is rejected, 4 cycles is accepted on instance A.
        for (int len = 3; len <= 4; len++) begin
            settle(2'b11);
            n_rise = 0; n_fall = 0;
            stim = 2'b01;
            for (int i = 0; i < 16; i++) begin
                if (i == len) stim = 2'b11;
                cycle();
                n_rise += int'(bus_a.rise[1]);
                n_fall += int'(bus_a.fall[1]);
            end
            check("glitch_rise", 32'(n_rise), 32'(len == 4 ? 1 : 0));
            check("glitch_fall", 32'(n_fall), 32'(len == 4 ? 1 : 0));
            $display("glitch len=%0d: rise=%0d fall=%0d", len, n_rise, n_fall);
        end

        // Instance B (STAGES=3, FILT_CYC=0): step latency and single-cycle pulse pass-through.
        settle(2'b11);
        stim = 2'b10;
        edge_at = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (bus_b.sig_filt[0] == 1'b0 && edge_at == 0) edge_at = i;
        end
        check("b_step_edge", 32'(edge_at), 32'(4));
        settle(2'b11);
        n_rise = 0; n_fall = 0;
        stim = 2'b10;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) stim = 2'b11;
            cycle();
            n_rise += int'(bus_b.rise[0]);
            n_fall += int'(bus_b.fall[0]);
        end
        check("b_pulse_cnt", 32'({n_rise[7:0], n_fall[7:0]}), 32'(16'h0101));
        $display("b sweep: step edge=%0d pulse rise=%0d fall=%0d", edge_at, n_rise, n_fall);

        // Randomised stretch with random event clears.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 2; c++)
                if ($urandom_range(3) == 0) stim[c] = ~stim[c];
            clr = 2'(($urandom_range(2) == 0) ? $urandom_range(3) : 0);
            cycle();
        end
        clr = 2'b00;
        $display("random phase done: total=%0d", total);

        // Asynchronous reset while instance A's filter count sits at 2.
        settle(2'b11);
        stim = 2'b10;
        for (int i = 0; i < 4; i++) cycle();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("midrst_filt", 32'(bus_a.sig_filt), 32'(2'b11));
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        $display("mid reset: filt=%b", bus_a.sig_filt);

`ifdef SYNC_EDGE_FLAG_EN
        // Sticky flag, explicit clear, then clear coinciding with a new rise.
        clr = 2'b11;
        settle(2'b00);
        clr = 2'b00;
        stim = 2'b01;
        for (int i = 0; i < 10; i++) cycle();
        check("flag_set", 32'(bus_a.rise_flag[0]), 32'(1));
        clr = 2'b01;
        cycle();
        clr = 2'b00;
        check("flag_clr", 32'(bus_a.rise_flag[0]), 32'(0));
        settle(2'b00);
        clr = 2'b11;
        cycle();
        clr = 2'b00;
        stim = 2'b01;
        for (int i = 0; i < 10; i++) begin
            cycle();
            clr = 2'b00;
            if (bus_a.rise[0]) clr = 2'b01;
        end
        check("flag_setwins", 32'(bus_a.rise_flag[0]), 32'(1));
        $display("flags: rise_flag=%b", bus_a.rise_flag);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
